// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Logic/arith ops finish in one cycle; shifts iterate one bit per cycle.
`timescale 1ns/1ps

module alu_exec_unit #(
    parameter int unsigned NB_DATA        = 32,
    parameter int unsigned NB_ALU_CONTROL = 4,
    parameter int unsigned NB_SHAMT       = 5
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [NB_ALU_CONTROL-1:0] i_alu_code,
    input  logic [NB_DATA-1:0]        i_dato_a,
    input  logic [NB_DATA-1:0]        i_dato_b,
    input  logic [NB_SHAMT-1:0]       i_shamt,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [NB_DATA-1:0]        o_result,
    output logic                      o_zero,
    output logic                      o_overflow
);

    localparam int unsigned HALF = NB_DATA / 2;

    localparam logic [NB_ALU_CONTROL-1:0] ALU_SLL  = NB_ALU_CONTROL'(4'b0000);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SRL  = NB_ALU_CONTROL'(4'b0001);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SRA  = NB_ALU_CONTROL'(4'b0010);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_LUI  = NB_ALU_CONTROL'(4'b0011);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_ADD  = NB_ALU_CONTROL'(4'b0100);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_ADDU = NB_ALU_CONTROL'(4'b0110);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SUBU = NB_ALU_CONTROL'(4'b0111);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_AND  = NB_ALU_CONTROL'(4'b1000);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_OR   = NB_ALU_CONTROL'(4'b1001);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_XOR  = NB_ALU_CONTROL'(4'b1010);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_NOR  = NB_ALU_CONTROL'(4'b1011);
    localparam logic [NB_ALU_CONTROL-1:0] ALU_SLT  = NB_ALU_CONTROL'(4'b1100);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [NB_SHAMT-1:0]       cnt_q, cnt_d;
    logic [NB_DATA-1:0]        acc_q, acc_d;
    logic [NB_ALU_CONTROL-1:0] code_q, code_d;
    logic [NB_DATA-1:0]        result_q, result_d;
    logic                      zero_q, zero_d;
    logic                      ovf_q, ovf_d;
    logic                      valid_q, valid_d;
    logic                      ready_q, ready_d;

    logic [NB_DATA-1:0]        sum_c;
    logic [NB_DATA-1:0]        alu_res_c;
    logic                      alu_ovf_c;
    logic                      is_shift_c;
    logic [NB_DATA-1:0]        acc_step_c;

    // Single-cycle datapath evaluated on the incoming operands
    always_comb begin
        sum_c      = i_dato_a + i_dato_b;
        alu_res_c  = '0;
        alu_ovf_c  = 1'b0;
        is_shift_c = (i_alu_code == ALU_SLL) || (i_alu_code == ALU_SRL) ||
                     (i_alu_code == ALU_SRA);
        case (i_alu_code)
            ALU_LUI:  alu_res_c = {i_dato_b[HALF-1:0], {HALF{1'b0}}};
            ALU_ADD: begin
                alu_res_c = sum_c;
                alu_ovf_c = (i_dato_a[NB_DATA-1] == i_dato_b[NB_DATA-1]) &&
                            (sum_c[NB_DATA-1] != i_dato_a[NB_DATA-1]);
            end
            ALU_ADDU: alu_res_c = sum_c;
            ALU_SUBU: alu_res_c = i_dato_a - i_dato_b;
            ALU_AND:  alu_res_c = i_dato_a & i_dato_b;
            ALU_OR:   alu_res_c = i_dato_a | i_dato_b;
            ALU_XOR:  alu_res_c = i_dato_a ^ i_dato_b;
            ALU_NOR:  alu_res_c = ~(i_dato_a | i_dato_b);
            ALU_SLT:  alu_res_c = NB_DATA'($signed(i_dato_a) < $signed(i_dato_b));
            default:  alu_res_c = '0;
        endcase
    end

    // One-bit shift step of the iterative shifter
    always_comb begin
        case (code_q)
            ALU_SRL: acc_step_c = {1'b0, acc_q[NB_DATA-1:1]};
            ALU_SRA: acc_step_c = {acc_q[NB_DATA-1], acc_q[NB_DATA-1:1]};
            default: acc_step_c = {acc_q[NB_DATA-2:0], 1'b0};
        endcase
    end

    // Next-state and output-register logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        code_d   = code_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    code_d = i_alu_code;
                    if (is_shift_c) begin
                        cnt_d   = i_shamt;
                        acc_d   = i_dato_b;
                        state_d = ST_SHIFT;
                    end else begin
                        result_d = alu_res_c;
                        zero_d   = (alu_res_c == '0);
                        ovf_d    = alu_ovf_c;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d = acc_step_c;
                    cnt_d = cnt_q - NB_SHAMT'(1);
                end else begin
                    result_d = acc_q;
                    zero_d   = (acc_q == '0);
                    ovf_d    = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            code_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            code_q   <= code_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_result   = result_q;
    assign o_zero     = zero_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit: single-cycle ops, iterative shifts,
// output backpressure and reset during a shift.
`timescale 1ns/1ps

module tb_alu_exec_unit;

    logic        i_clock;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_alu_code;
    logic [31:0] i_dato_a;
    logic [31:0] i_dato_b;
    logic [4:0]  i_shamt;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_overflow;

    int n_checks;
    int n_fail;

    alu_exec_unit #(
        .NB_DATA        (32),
        .NB_ALU_CONTROL (4),
        .NB_SHAMT       (5)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_alu_code (i_alu_code),
        .i_dato_a   (i_dato_a),
        .i_dato_b   (i_dato_b),
        .i_shamt    (i_shamt),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_zero     (o_zero),
        .o_overflow (o_overflow)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Single-cycle op vectors: code, A, B, result, zero, overflow
    localparam int N_OPS = 16;
    localparam logic [3:0]  OP_CODE [N_OPS] = '{4'h6, 4'h4, 4'h6, 4'h4, 4'h4, 4'h7, 4'h8, 4'h9,
                                                4'hA, 4'hB, 4'hC, 4'hC, 4'h3, 4'hF, 4'h5, 4'hD};
    localparam logic [31:0] OP_A [N_OPS] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                                             32'hFFFF_FFFF, 32'h0000_0005, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                                             32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0000_0001,
                                             32'h1234_5678, 32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF};
    localparam logic [31:0] OP_B [N_OPS] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000,
                                             32'h0000_0001, 32'h0000_0007, 32'hFF00_FF00, 32'hFF00_FF00,
                                             32'hFF00_FF00, 32'hFF00_FF00, 32'h0000_0001, 32'hFFFF_FFFF,
                                             32'h0000_ABCD, 32'h9ABC_DEF0, 32'h0000_0002, 32'hFFFF_FFFF};
    localparam logic [31:0] OP_RES [N_OPS] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000,
                                               32'h0000_0000, 32'hFFFF_FFFE, 32'hF000_F000, 32'hFFF0_FFF0,
                                               32'h0FF0_0FF0, 32'h000F_000F, 32'h0000_0001, 32'h0000_0000,
                                               32'hABCD_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic OP_Z [N_OPS] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic OP_OV [N_OPS] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Shift vectors: code, B, shamt, result, zero, edges from accept to o_valid
    localparam int N_SH = 6;
    localparam logic [3:0]  SH_CODE [N_SH] = '{4'h2, 4'h1, 4'h0, 4'h0, 4'h2, 4'h1};
    localparam logic [31:0] SH_B [N_SH] = '{32'h8000_0000, 32'h8000_0000, 32'h1234_5678,
                                            32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [4:0]  SH_AMT [N_SH] = '{5'd4, 5'd4, 5'd0, 5'd31, 5'd31, 5'd1};
    localparam logic [31:0] SH_RES [N_SH] = '{32'hF800_0000, 32'h0800_0000, 32'h1234_5678,
                                              32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
    localparam logic SH_Z [N_SH] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam int SH_LAT [N_SH] = '{5, 5, 1, 32, 32, 2};

    // Waits for o_ready, issues one op, returns edges after the accept edge until o_valid (-1 on timeout)
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, output int lat);
        int w;
        w = 0;
        while (!o_ready && w < 50) begin
            @(posedge i_clock); #1;
            w++;
        end
        if (!o_ready) begin
            lat = -1;
            return;
        end
        i_valid    = 1'b1;
        i_alu_code = code;
        i_dato_a   = a;
        i_dato_b   = b;
        i_shamt    = sh;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(posedge i_clock); #1;
            lat++;
        end
        if (!o_valid) lat = -1;
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(posedge i_clock); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_checks++;
        if (o_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", o_result); end
        n_checks++;
        if (o_zero !== 1'b0 || o_overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got zero=%b ovf=%b expected 0 0", o_zero, o_overflow);
        end
    endtask

    task automatic test_single_cycle();
        int lat;
        for (int i = 0; i < N_OPS; i++) begin
            run_op(OP_CODE[i], OP_A[i], OP_B[i], 5'd0, lat);
            n_checks++;
            if (lat !== 0) begin n_fail++; $display("FAIL op%0d_latency: got %0d expected 0", i, lat); end
            n_checks++;
            if (o_result !== OP_RES[i]) begin
                n_fail++; $display("FAIL op%0d_result code=%h: got %h expected %h", i, OP_CODE[i], o_result, OP_RES[i]);
            end
            n_checks++;
            if (o_zero !== OP_Z[i]) begin n_fail++; $display("FAIL op%0d_zero: got %b expected %b", i, o_zero, OP_Z[i]); end
            n_checks++;
            if (o_overflow !== OP_OV[i]) begin
                n_fail++; $display("FAIL op%0d_overflow: got %b expected %b", i, o_overflow, OP_OV[i]);
            end
            consume();
        end
    endtask

    task automatic test_shifts();
        int lat;
        for (int i = 0; i < N_SH; i++) begin
            run_op(SH_CODE[i], 32'hDEAD_BEEF, SH_B[i], SH_AMT[i], lat);
            n_checks++;
            if (lat !== SH_LAT[i]) begin n_fail++; $display("FAIL sh%0d_latency: got %0d expected %0d", i, lat, SH_LAT[i]); end
            n_checks++;
            if (o_result !== SH_RES[i]) begin
                n_fail++; $display("FAIL sh%0d_result code=%h: got %h expected %h", i, SH_CODE[i], o_result, SH_RES[i]);
            end
            n_checks++;
            if (o_zero !== SH_Z[i] || o_overflow !== 1'b0) begin
                n_fail++; $display("FAIL sh%0d_flags: got zero=%b ovf=%b expected %b 0", i, o_zero, o_overflow, SH_Z[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(4'h6, 32'h0000_0001, 32'h0000_0002, 5'd0, lat);
        for (int c = 0; c < 3; c++) begin
            i_valid  = 1'b1;
            i_alu_code = 4'h7;
            i_dato_a = 32'h1111_0000 + 32'(c);
            i_dato_b = 32'h0000_0001;
            @(posedge i_clock); #1;
            n_checks++;
            if (o_result !== 32'h0000_0003 || o_valid !== 1'b1 || o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: got result=%h valid=%b ready=%b expected 00000003 1 0",
                         c, o_result, o_valid, o_ready);
            end
        end
        i_valid = 1'b0;
        consume();
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL release: got ready=%b valid=%b expected 1 0", o_ready, o_valid);
        end
        n_checks++;
        if (o_result !== 32'h0000_0003) begin n_fail++; $display("FAIL release_hold: got %h expected 00000003", o_result); end
    endtask

    task automatic test_reset_mid_shift();
        int  lat;
        int  w;
        logic late;
        w = 0;
        while (!o_ready && w < 50) begin @(posedge i_clock); #1; w++; end
        i_valid    = 1'b1;
        i_alu_code = 4'h2;
        i_dato_a   = 32'h0;
        i_dato_b   = 32'h8000_0000;
        i_shamt    = 5'd20;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        repeat (4) begin @(posedge i_clock); #1; end
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_shift: got valid=%b ready=%b expected 0 0", o_valid, o_ready);
        end
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'h0) begin
            n_fail++;
            $display("FAIL shift_reset: got valid=%b ready=%b result=%h expected 0 1 00000000",
                     o_valid, o_ready, o_result);
        end
        late = 1'b0;
        repeat (30) begin
            @(posedge i_clock); #1;
            if (o_valid) late = 1'b1;
        end
        n_checks++;
        if (late !== 1'b0) begin n_fail++; $display("FAIL late_result: got %b expected 0", late); end
        run_op(4'h6, 32'h0000_0002, 32'h0000_0003, 5'd0, lat);
        n_checks++;
        if (lat !== 0 || o_result !== 32'h0000_0005) begin
            n_fail++; $display("FAIL post_reset_op: got lat=%0d result=%h expected 0 00000005", lat, o_result);
        end
        consume();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        i_reset    = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_alu_code = 4'h0;
        i_dato_a   = 32'h0;
        i_dato_b   = 32'h0;
        i_shamt    = 5'd0;
        test_reset();
        test_single_cycle();
        test_shifts();
        test_backpressure();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
